// File: rtl/binarize_pkg.sv
// Shared sizes, FSM state type and tile slot helper for the tile binarization controller.
package binarize_pkg;

   localparam int PIX_W     = 8;
   localparam int TILE_W    = 3;
   localparam int TILE_H    = 3;
   localparam int CNT_W     = 16;
   localparam int TILE_PIX  = TILE_W * TILE_H;
   localparam int TILE_BITS = TILE_PIX * PIX_W;
   localparam int IDX_W     = $clog2(TILE_PIX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      EVAL  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // Pixel 0 occupies the most significant byte of the packed tile.
   function automatic int slot_lsb(input int n);
      return TILE_BITS - PIX_W * (n + 1);
   endfunction

endpackage

// File: rtl/tile_pack_buf.sv
// Packed tile register written one pixel at a time into slot wr_idx.
// Slots that are not written keep their previous pixel.
module tile_pack_buf
   import binarize_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic [IDX_W-1:0]     wr_idx,
   input  logic [PIX_W-1:0]     wr_pixel,
   output logic [TILE_BITS-1:0] tile
);

   // Indexed byte write into the packed tile.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tile <= '0;
      end else if (wr_en) begin
         for (int n = 0; n < TILE_PIX; n++) begin
            if (wr_idx == IDX_W'(n)) begin
               tile[slot_lsb(n) +: PIX_W] <= wr_pixel;
            end
         end
      end
   end

endmodule

// File: rtl/binarize_tile_ctrl.sv
// Tile sequencer for the 3x3 local-mean binarization datapath: collects a tile,
// lets the external datapath evaluate it for one cycle, then drains one bit per pixel.
//
// state | meaning
// IDLE  | waiting for start; num_tiles==0 finishes at once with a done pulse
// FILL  | accepting raster-order pixels into the packed tile
// EVAL  | single cycle; dp_in stable, datapath result captured at the end
// DRAIN | presenting one result bit per pixel downstream
module binarize_tile_ctrl
   import binarize_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [CNT_W-1:0]     num_tiles,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [PIX_W-1:0]     s_pixel,
   output logic [TILE_BITS-1:0] dp_in,
   input  logic [TILE_BITS-1:0] dp_out,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_bit,
   output logic                 m_last,
   output logic                 busy,
   output logic                 done
);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     num_q;
   logic [CNT_W-1:0]     tile_cnt_q;
   logic [IDX_W-1:0]     pix_idx_q;
   logic [IDX_W-1:0]     out_idx_q;
   logic [TILE_PIX-1:0]  result_q;
   logic                 done_q;

   logic s_accept;
   logic m_hs;
   logic last_pix;
   logic last_bit;
   logic last_tile;
   logic dp_out_unused;

   assign s_accept  = s_valid && s_ready;
   assign m_hs      = m_valid && m_ready;
   assign last_pix  = (pix_idx_q == IDX_W'(TILE_PIX - 1));
   assign last_bit  = (out_idx_q == IDX_W'(TILE_PIX - 1));
   assign last_tile = (tile_cnt_q == num_q - 1'b1);

   // Every byte of dp_out is all-0 or all-1, so only each byte's MSB is looked at.
   assign dp_out_unused = ^dp_out;

   assign busy   = (state_q != IDLE);
   assign done   = done_q;
   assign m_bit  = (state_q == DRAIN) ? result_q[out_idx_q] : 1'b0;
   assign m_last = (state_q == DRAIN) && last_bit && last_tile;

   tile_pack_buf u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (s_accept),
      .wr_idx   (pix_idx_q),
      .wr_pixel (s_pixel),
      .tile     (dp_in)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake outputs; s_ready depends only on state.
   always_comb begin
      state_d = state_q;
      s_ready = 1'b0;
      m_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && (num_tiles != '0)) begin
               state_d = FILL;
            end
         end
         FILL: begin
            s_ready = 1'b1;
            if (s_accept && last_pix) begin
               state_d = EVAL;
            end
         end
         EVAL: begin
            state_d = DRAIN;
         end
         DRAIN: begin
            m_valid = 1'b1;
            if (m_hs && last_bit) begin
               state_d = last_tile ? IDLE : FILL;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Job length latch plus tile, pixel and output counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_q      <= '0;
         tile_cnt_q <= '0;
         pix_idx_q  <= '0;
         out_idx_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  num_q      <= num_tiles;
                  tile_cnt_q <= '0;
                  pix_idx_q  <= '0;
               end
            end
            FILL: begin
               if (s_accept) begin
                  pix_idx_q <= pix_idx_q + 1'b1;
               end
            end
            EVAL: begin
               out_idx_q <= '0;
            end
            DRAIN: begin
               if (m_hs) begin
                  if (last_bit) begin
                     out_idx_q <= '0;
                     if (!last_tile) begin
                        tile_cnt_q <= tile_cnt_q + 1'b1;
                        pix_idx_q  <= '0;
                     end
                  end else begin
                     out_idx_q <= out_idx_q + 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Capture the datapath verdict for each pixel at the end of EVAL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
      end else if (state_q == EVAL) begin
         for (int n = 0; n < TILE_PIX; n++) begin
            result_q[n] <= dp_out[slot_lsb(n) + PIX_W - 1];
         end
      end
   end

   // One-cycle done pulse: empty job, or final handshake of the final tile.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
      end else begin
         done_q <= ((state_q == IDLE) && start && (num_tiles == '0)) ||
                   ((state_q == DRAIN) && m_hs && last_bit && last_tile);
      end
   end

endmodule

// File: tb/tb_binarize_tile_ctrl.sv
// Scoreboard bench for binarize_tile_ctrl with a behavioural 3x3 local-mean datapath.
`timescale 1ns/1ps
module tb_binarize_tile_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] num_tiles;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_pixel;
   logic [71:0] dp_in;
   logic [71:0] dp_out;
   logic        m_valid;
   logic        m_ready;
   logic        m_bit;
   logic        m_last;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_errors = 0;

   int cyc = 0;
   int hs_cnt = 0;
   int done_cnt = 0;
   int last_cnt = 0;
   int vcyc = 0;
   int done_cyc = -1;
   int last_hs_cyc = -1;
   int fill_cyc = -1;
   int st_cyc = 0;
   bit busy_seen = 0;
   bit srdy_seen = 0;

   logic [1:0] sb[$];

   binarize_tile_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .num_tiles (num_tiles),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_pixel   (s_pixel),
      .dp_in     (dp_in),
      .dp_out    (dp_out),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_bit     (m_bit),
      .m_last    (m_last),
      .busy      (busy),
      .done      (done)
   );

   // 3x3 local mean with zero padding: background (all-1 byte) when pixel >= mean.
   function automatic logic [71:0] dp_model(input logic [71:0] t);
      logic [71:0] r;
      int row, col, rr, cc, sum, pv;
      r = '0;
      for (int n = 0; n < 9; n++) begin
         row = n / 3;
         col = n % 3;
         sum = 0;
         for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
               rr = row + dr;
               cc = col + dc;
               if (rr >= 0 && rr < 3 && cc >= 0 && cc < 3)
                  sum += int'(t[71 - 8 * (rr * 3 + cc) -: 8]);
            end
         end
         pv = int'(t[71 - 8 * n -: 8]);
         r[71 - 8 * n -: 8] = (pv * 9 >= sum) ? 8'hFF : 8'h00;
      end
      return r;
   endfunction

   assign dp_out = dp_model(dp_in);

   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Monitor: pops the scoreboard on every output handshake and tracks timing events.
   initial begin : monitor
      logic [1:0] expv;
      bit stall_prev;
      bit held_bit, held_last, busy_prev;
      stall_prev = 0;
      held_bit = 0;
      held_last = 0;
      busy_prev = 0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (m_valid) vcyc++;
            if (stall_prev && m_valid) begin
               n_checks++;
               if (m_bit !== held_bit || m_last !== held_last) begin
                  n_errors++;
                  $display("FAIL stall_hold: got bit=%0b last=%0b expected bit=%0b last=%0b",
                           m_bit, m_last, held_bit, held_last);
               end
            end
            stall_prev = m_valid && !m_ready;
            held_bit   = m_bit;
            held_last  = m_last;
            if (m_valid && m_ready) begin
               hs_cnt++;
               if (m_last) begin
                  last_cnt++;
                  last_hs_cyc = cyc;
               end
               n_checks++;
               if (sb.size() == 0) begin
                  n_errors++;
                  $display("FAIL out_bit: got unexpected bit=%0b last=%0b expected no output",
                           m_bit, m_last);
               end else begin
                  expv = sb.pop_front();
                  if ({m_last, m_bit} !== expv) begin
                     n_errors++;
                     $display("FAIL out_bit: got last=%0b bit=%0b expected last=%0b bit=%0b",
                              m_last, m_bit, expv[1], expv[0]);
                  end
               end
            end
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            if (busy) busy_seen = 1;
            if (s_ready) srdy_seen = 1;
            if (busy && !busy_prev) fill_cyc = cyc;
            busy_prev = busy;
         end else begin
            stall_prev = 0;
            busy_prev  = 0;
         end
      end
   end

   task automatic push_tile(input logic [8:0] bits, input bit last_tile);
      for (int n = 0; n < 9; n++)
         sb.push_back({last_tile && (n == 8), bits[8 - n]});
   endtask

   task automatic start_job(input logic [15:0] n);
      @(posedge clk);
      #1;
      num_tiles = n;
      start = 1;
      st_cyc = cyc;
      @(posedge clk);
      #1;
      start = 0;
   endtask

   // Presents the 9 pixels; s_valid is left high so the next tile can follow at once.
   task automatic send_tile(input logic [71:0] t);
      bit ok;
      for (int p = 0; p < 9; p++) begin
         s_valid = 1;
         s_pixel = t[71 - 8 * p -: 8];
         ok = 0;
         for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (s_ready) ok = 1;
         end
         if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL s_ready_timeout: got s_ready=0 expected 1 at pixel %0d", p);
            return;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_done(input int bound);
      int base;
      bit ok;
      base = done_cnt;
      ok = 0;
      for (int k = 0; k < bound && !ok; k++) begin
         @(posedge clk);
         if (done_cnt > base) ok = 1;
      end
      if (!ok) begin
         n_checks++;
         n_errors++;
         $display("FAIL done_timeout: got no done expected done within %0d cycles", bound);
      end
      #1;
   endtask

   localparam logic [71:0] TILE_FLAT   = {9{8'h40}};
   localparam logic [71:0] TILE_CENTER = {32'h0, 8'hFF, 32'h0};
   localparam logic [71:0] TILE_CORNER = {8'hFF, 64'h0};

   initial begin : stim
      int base_done, base_hs, base_last, base_v;
      rst_n = 0;
      start = 0;
      num_tiles = '0;
      s_valid = 0;
      s_pixel = '0;
      m_ready = 1;

      #12;
      check("reset_outputs", {s_ready, m_valid, m_bit, m_last, busy, done, dp_in}, '0);
      @(negedge clk);
      rst_n = 1;

      // 1: flat tile, every pixel equals its local mean or exceeds the padded mean
      push_tile(9'b111111111, 1);
      base_hs = hs_cnt;
      base_done = done_cnt;
      start_job(16'd1);
      send_tile(TILE_FLAT);
      s_valid = 0;
      wait_done(100);
      check("t1_handshakes", hs_cnt - base_hs, 9);
      check("t1_done_count", done_cnt - base_done, 1);
      check("t1_done_timing", done_cyc, last_hs_cyc + 1);

      // 2: single bright centre pixel
      push_tile(9'b000010000, 1);
      start_job(16'd1);
      send_tile(TILE_CENTER);
      s_valid = 0;
      wait_done(100);
      check("t2_done_timing", done_cyc, last_hs_cyc + 1);

      // 3: same tile with downstream stalling every other cycle
      push_tile(9'b000010000, 1);
      base_done = done_cnt;
      start_job(16'd1);
      send_tile(TILE_CENTER);
      s_valid = 0;
      m_ready = 0;
      base_v = vcyc;
      @(posedge clk);
      #1;
      for (int k = 0; k < 100 && done_cnt == base_done; k++) begin
         @(posedge clk);
         #1;
         m_ready = ~m_ready;
      end
      m_ready = 1;
      check("t3_drain_cycles", vcyc - base_v, 18);
      check("t3_done_count", done_cnt - base_done, 1);

      // 4: empty job
      repeat (2) @(posedge clk);
      busy_seen = 0;
      srdy_seen = 0;
      base_done = done_cnt;
      start_job(16'd0);
      repeat (3) @(posedge clk);
      #1;
      check("t4_done_count", done_cnt - base_done, 1);
      check("t4_done_timing", done_cyc, st_cyc + 1);
      check("t4_busy_seen", busy_seen, 0);
      check("t4_s_ready_seen", srdy_seen, 0);

      // 5: reset in the middle of DRAIN after 4 handshakes
      push_tile(9'b000010000, 1);
      base_hs = hs_cnt;
      start_job(16'd1);
      send_tile(TILE_CENTER);
      s_valid = 0;
      for (int k = 0; k < 100 && (hs_cnt - base_hs) < 4; k++) @(posedge clk);
      check("t5_hs_before_reset", hs_cnt - base_hs, 4);
      base_done = done_cnt;
      #2;
      rst_n = 0;
      #1;
      check("t5_reset_outputs", {s_ready, m_valid, m_bit, m_last, busy, done, dp_in}, '0);
      sb.delete();
      @(negedge clk);
      rst_n = 1;
      repeat (2) @(posedge clk);
      #1;
      check("t5_no_done_on_reset", done_cnt - base_done, 0);
      push_tile(9'b111111111, 1);
      base_hs = hs_cnt;
      start_job(16'd1);
      send_tile(TILE_FLAT);
      s_valid = 0;
      wait_done(100);
      check("t5_restart_handshakes", hs_cnt - base_hs, 9);
      check("t5_restart_done", done_cnt - base_done, 1);

      // 6: three back-to-back tiles, no stalls, stray start mid-job
      push_tile(9'b111111111, 0);
      push_tile(9'b000010000, 0);
      push_tile(9'b101001111, 1);
      base_done = done_cnt;
      base_hs = hs_cnt;
      base_last = last_cnt;
      fork
         begin
            start_job(16'd3);
            send_tile(TILE_FLAT);
            send_tile(TILE_CENTER);
            send_tile(TILE_CORNER);
            s_valid = 0;
         end
         begin
            repeat (30) @(posedge clk);
            #1;
            start = 1;
            num_tiles = 16'd5;
            @(posedge clk);
            #1;
            start = 0;
         end
      join
      wait_done(200);
      check("t6_handshakes", hs_cnt - base_hs, 27);
      check("t6_done_latency", done_cyc - fill_cyc, 57);
      check("t6_last_count", last_cnt - base_last, 1);
      check("t6_done_count", done_cnt - base_done, 1);
      repeat (3) @(posedge clk);
      #1;
      check("t6_idle_after", busy, 0);
      check("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
